imm_decode_ctrl: RTL and testbench
==================================

// Module: imm_decode_ctrl
// PURPOSE
//  Decode-stage controller for the 3-stage pipeline: registers the fetched instruction/PC under a
//  valid/ready handshake, classifies the opcode, and drives the immediate generator's select
//  (immediate_type) and instruction inputs. Sits between fetch and execute; handles stall
//  backpressure and branch/jump flush so the immediate generator always sees a stable word.
// PARAMETERS
//  XLEN      32            datapath / PC width
//  NOP_INSN  32'h00000013  word held in instr_q when the stage is empty (addi x0,x0,0)
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     reset, synchronous, active-high
//  in_valid     in   1     fetch presents instruction
//  in_ready     out  1     stage can accept this cycle
//  in_instr     in   32    fetched instruction
//  in_pc        in   XLEN  PC of in_instr
//  flush        in   1     kill stage contents (taken branch/jump from execute)
//  out_valid    out  1     decoded instruction available to execute
//  out_ready    in   1     execute accepts this cycle
//  instr_q      out  32    registered instruction -> immediate generator 'instruction'
//  pc_q         out  XLEN  registered PC
//  imm_type     out  3     -> immediate generator 'immediate_type'
//  imm_used     out  1     instruction consumes an immediate
//  illegal      out  1     opcode not recognised
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, instr_q=NOP_INSN, pc_q=0, imm_type=3'b000, imm_used=1,
//    illegal=0; skid entry (if present) invalidated. rst overrides flush and all handshakes.
//  - FSM (base): EMPTY, FULL. EMPTY--in_valid-->FULL; FULL--out_ready&!in_valid-->EMPTY;
//    FULL--out_ready&in_valid-->FULL (new word); FULL--!out_ready-->FULL (hold, outputs stable).
//  - in_ready = !out_valid | out_ready (combinational). Transfer in = in_valid&in_ready;
//    transfer out = out_valid&out_ready. Latency in->out: 1 cycle.
//  - imm_type/imm_used/illegal are registered, computed from in_instr[6:0] at capture:
//    0010011,0000011,1100111,1110011 -> 000 (I); 1101111 -> 001 (J); 0110111,0010111 -> 010 (U);
//    1100011 -> 011 (B); 0100011 -> 100 (S); 0110011 -> 000, imm_used=0;
//    any other -> 000, imm_used=0, illegal=1. imm_type never leaves 000..100.
//  - Hold: while out_valid&!out_ready, instr_q/pc_q/imm_type/imm_used/illegal must not change.
//  - flush=1: next cycle out_valid=0, instr_q=NOP_INSN, imm_type=000, imm_used=1, illegal=0,
//    state EMPTY; in_ready is forced 0 in the flush cycle (no capture), skid discarded.
//  - Simultaneous flush & out_ready: the outgoing transfer completes; new word is not captured.
//  - pc_q captured unmodified, full XLEN width; no arithmetic on PC.
// CONFIGURATION
//  IMM_DEC_SKID_EN defined: adds one-entry skid buffer; FSM EMPTY/FULL/SKID. in_ready is a
//    register (=!skid_valid), no combinational path out_ready->in_ready. Word accepted while
//    FULL&!out_ready goes to skid (state SKID); on out_ready skid moves to output next cycle.
//    Order strictly preserved; flush clears both entries. Decode of skid word at skid capture.
//  Not defined: single register, in_ready = !out_valid | out_ready as above.
// TESTING
//  1 rst=1 two cycles, then release -> out_valid=0, instr_q=32'h00000013, imm_type=000, illegal=0.
//  2 in 0x00500093(addi),0x008000EF(jal),0x123452B7(lui),0x00208463(beq),0x00112223(sw),
//    out_ready=1 -> imm_type 000,001,010,011,100 one cycle after each; imm_used=1 each.
//  3 in 0x002081B3(add) -> imm_used=0, illegal=0; in 0xFFFFFFFF -> illegal=1, imm_type=000.
//  4 capture 0x00500093, hold out_ready=0 five cycles with in_valid=1 (0x008000EF) -> instr_q
//    stable, no loss; out_ready=1 -> both delivered in order (skid build: in_ready deasserts after one).
//  5 flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, instr_q=NOP, word dropped;
//    flush&out_ready same cycle -> current word counted as transferred.
//  6 rst=1 while FULL (and SKID) -> next cycle out_valid=0, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/imm_decode_ctrl_if.sv
// Fetch -> decode -> execute handshake bundle for imm_decode_ctrl.
// master drives fetch/execute side, slave is the decode stage.
interface imm_decode_ctrl_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q;
   logic [2:0]      imm_type;
   logic            imm_used;
   logic            illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, instr_q, pc_q,
      input  imm_type, imm_used, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, instr_q, pc_q,
      output imm_type, imm_used, illegal
   );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode-stage register + opcode classifier feeding the immediate generator.
// Define IMM_DEC_SKID_EN to add a one-entry skid buffer (registered in_ready).
module imm_decode_ctrl #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input logic             clk,
   input logic             rst,
   imm_decode_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      EMPTY,
      FULL,
      SKID
   } state_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [2:0]      imm_type;
      logic            imm_used;
      logic            illegal;
   } word_t;

   function automatic word_t idle(input logic [XLEN-1:0] pc);
      word_t w;
      w.instr    = NOP_INSN;
      w.pc       = pc;
      w.imm_type = 3'b000;
      w.imm_used = 1'b1;
      w.illegal  = 1'b0;
      return w;
   endfunction

   function automatic word_t decode(
      input logic [31:0]     instr,
      input logic [XLEN-1:0] pc
   );
      word_t      w;
      logic [6:0] op;
      op         = instr[6:0];
      w          = idle(pc);
      w.instr    = instr;
      unique case (1'b1)
         (op == 7'b0010011) || (op == 7'b0000011) ||
         (op == 7'b1100111) || (op == 7'b1110011): begin
            w.imm_type = 3'b000;
         end
         op == 7'b1101111: w.imm_type = 3'b001;
         (op == 7'b0110111) || (op == 7'b0010111): begin
            w.imm_type = 3'b010;
         end
         op == 7'b1100011: w.imm_type = 3'b011;
         op == 7'b0100011: w.imm_type = 3'b100;
         op == 7'b0110011: w.imm_used = 1'b0;
         default: begin
            w.imm_used = 1'b0;
            w.illegal  = 1'b1;
         end
      endcase
      return w;
   endfunction

   state_t state;
   word_t  cur;
   word_t  in_w;

   always_comb begin
      in_w = decode(bus.in_instr, bus.in_pc);
   end

   assign bus.out_valid = (state != EMPTY);
   assign bus.instr_q   = cur.instr;
   assign bus.pc_q      = cur.pc;
   assign bus.imm_type  = cur.imm_type;
   assign bus.imm_used  = cur.imm_used;
   assign bus.illegal   = cur.illegal;

`ifdef IMM_DEC_SKID_EN
   word_t skid;
   logic  skid_valid;

   // in_ready depends only on state and flush, never on out_ready
   assign bus.in_ready = !skid_valid && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         cur        <= idle('0);
         skid       <= idle('0);
         skid_valid <= 1'b0;
      end else if (bus.flush) begin
         state      <= EMPTY;
         cur        <= idle(cur.pc);
         skid_valid <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (bus.in_valid) begin
                  cur   <= in_w;
                  state <= FULL;
               end
            end
            FULL: begin
               if (bus.out_ready) begin
                  if (bus.in_valid) begin
                     cur <= in_w;
                  end else begin
                     cur   <= idle(cur.pc);
                     state <= EMPTY;
                  end
               end else if (bus.in_valid) begin
                  skid       <= in_w;
                  skid_valid <= 1'b1;
                  state      <= SKID;
               end
            end
            SKID: begin
               if (bus.out_ready) begin
                  cur        <= skid;
                  skid_valid <= 1'b0;
                  state      <= FULL;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
`else
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         cur   <= idle('0);
      end else if (bus.flush) begin
         state <= EMPTY;
         cur   <= idle(cur.pc);
      end else begin
         unique case (state)
            EMPTY: begin
               if (bus.in_valid) begin
                  cur   <= in_w;
                  state <= FULL;
               end
            end
            FULL: begin
               if (bus.out_ready) begin
                  if (bus.in_valid) begin
                     cur <= in_w;
                  end else begin
                     cur   <= idle(cur.pc);
                     state <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
`endif
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: directed cases plus random traffic.
// Stimulus pushes expected words on acceptance; a monitor pops on delivery.
module tb_imm_decode_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imm_decode_ctrl_if #(.XLEN(32)) bus ();

   imm_decode_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  t;
      logic        used;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] opc_tab [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h6F,
                                7'h37, 7'h17, 7'h63, 7'h23, 7'h33};
   logic [2:0] typ_tab [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                                3'd2, 3'd2, 3'd3, 3'd4, 3'd0};

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      e.instr = w;
      e.pc    = pc;
      e.t     = 3'd0;
      e.used  = 1'b0;
      e.ill   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (w[6:0] == opc_tab[i]) begin
            e.t    = typ_tab[i];
            e.used = (opc_tab[i] != 7'h33);
            e.ill  = 1'b0;
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [31:0] w,
                        input logic [31:0] pc, input logic ordy,
                        input logic fl, output bit acc);
      bus.in_valid  = v;
      bus.in_instr  = w;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
      #1;
      acc = !rst && v && bus.in_ready;
      if (acc) sb.push_back(model(w, pc));
   endtask

   // Monitor: pop on delivery, and outputs must not move while stalled.
   exp_t held;
   bit   hold_v = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         hold_v = 0;
      end else begin
         if (hold_v) begin
            chk("hold_instr", bus.instr_q, held.instr);
            chk("hold_pc", bus.pc_q, held.pc);
            chk("hold_dec", {bus.imm_type, bus.imm_used, bus.illegal},
                {held.t, held.used, held.ill});
         end
         hold_v     = bus.out_valid && !bus.out_ready && !bus.flush;
         held.instr = bus.instr_q;
         held.pc    = bus.pc_q;
         held.t     = bus.imm_type;
         held.used  = bus.imm_used;
         held.ill   = bus.illegal;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("out_instr", bus.instr_q, e.instr);
               chk("out_pc", bus.pc_q, e.pc);
               chk("out_imm_type", bus.imm_type, e.t);
               chk("out_imm_used", bus.imm_used, e.used);
               chk("out_illegal", bus.illegal, e.ill);
            end
         end
         if (bus.flush) sb.delete();
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_instr_q"}, bus.instr_q, 32'h0000_0013);
      chk({tag, "_imm_type"}, bus.imm_type, 3'b000);
      chk({tag, "_imm_used"}, bus.imm_used, 1'b1);
      chk({tag, "_illegal"}, bus.illegal, 1'b0);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
   endtask

   logic [31:0] dir_w [7] = '{32'h0050_0093, 32'h0080_00EF, 32'h1234_52B7,
                              32'h0020_8463, 32'h0011_2223, 32'h0020_81B3,
                              32'hFFFF_FFFF};
   logic [2:0]  dir_t [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
   logic        dir_u [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic        dir_i [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      bit          acc;
      bit          got;
      logic [31:0] w;
      int          r;

      rst = 1'b1;
      issue(0, 32'h0, 32'h0, 0, 0, acc);
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_pc_q", bus.pc_q, 32'h0);

      // one word per cycle, each decoded the cycle after capture
      for (int i = 0; i < 7; i++) begin
         issue(1, dir_w[i], 32'h100 + 32'(i * 4), 1, 0, acc);
         tick();
         chk("dir_imm_type", bus.imm_type, dir_t[i]);
         chk("dir_imm_used", bus.imm_used, dir_u[i]);
         chk("dir_illegal", bus.illegal, dir_i[i]);
      end
      issue(0, 32'h0, 32'h0, 1, 0, acc);
      tick();

      // stall with a second word pending
      issue(1, 32'h0050_0093, 32'h200, 0, 0, acc);
      tick();
      got = 0;
      for (int i = 0; i < 5; i++) begin
         issue(!got, 32'h0080_00EF, 32'h204, 0, 0, acc);
         got = got | acc;
         tick();
         chk("stall_instr_q", bus.instr_q, 32'h0050_0093);
         chk("stall_in_ready", bus.in_ready, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         issue(!got, 32'h0080_00EF, 32'h204, 1, 0, acc);
         got = got | acc;
         tick();
      end
      chk("stall_second_taken", got, 1'b1);

      // flush with a waiting word
      issue(1, 32'h0050_0093, 32'h300, 0, 0, acc);
      tick();
      issue(1, 32'h1234_52B7, 32'h304, 0, 1, acc);
      chk("flush_in_ready", bus.in_ready, 1'b0);
      tick();
      issue(0, 32'h0, 32'h0, 0, 0, acc);
      chk_idle("flush");
      // flush together with out_ready: word still delivered
      issue(1, 32'h0011_2223, 32'h308, 1, 0, acc);
      tick();
      issue(0, 32'h0, 32'h0, 1, 1, acc);
      tick();
      issue(0, 32'h0, 32'h0, 0, 0, acc);
      chk_idle("flush_xfer");

      // reset while full (and skid occupied if present)
      issue(1, 32'h0020_8463, 32'hABC0, 0, 0, acc);
      tick();
      issue(1, 32'h0080_00EF, 32'hABC4, 0, 0, acc);
      tick();
      rst = 1'b1;
      issue(0, 32'h0, 32'h0, 0, 0, acc);
      tick();
      rst = 1'b0;
      chk_idle("rst_full");
      chk("rst_full_pc_q", bus.pc_q, 32'h0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 11);
         w = $urandom;
         if (r < 10) w[6:0] = opc_tab[r];
         rst = ($urandom_range(0, 499) == 0);
         issue($urandom_range(0, 9) < 7, w, $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4, acc);
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(0, 32'h0, 32'h0, 1, 0, acc);
         tick();
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      chk("drain_out_valid", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
